// File: rtl/aes_decrypt_ctrl.sv
// ---------------------------------------------------------------------------
// aes_decrypt_ctrl
//
// Control FSM for the AES-128 decryption datapath behind the Avalon AES
// register file. A run starts when AES_START is seen high in IDLE. The FSM
// then sequences:
//   - key expansion for KEYEXP_CYCLES cycles
//   - one message load
//   - the initial AddRoundKey with round key 10
//   - 9 full inverse rounds (ISR, ISB, ARK, 4x IMC)
//   - one final inverse round (ISR, ISB, ARK with round key 0)
// Each cycle it drives the operation select, round-key index and column
// select into a shared single-column InvMixColumns datapath.
//
// All outputs are registered. They are computed on the same edge that
// enters a state, so they always describe the current state.
//
// Ports:
//   CLK        in   system clock, all state on rising edge
//   RESET_N    in   asynchronous active-low reset
//   AES_START  in   start level (bit 0 of the start register)
//   AES_DONE   out  decryption complete (bit 0 of the done register)
//   BUSY       out  high in every state other than IDLE and DONE
//   KEYEXP_EN  out  key-expansion unit enable
//   MSG_LD     out  load state register from the encrypted-message registers
//   STATE_LD   out  load state register from the datapath output
//   OP_SEL     out  0 none, 1 AddRoundKey, 2 InvShiftRows,
//                   3 InvSubBytes, 4 InvMixColumns
//   ROUND_IDX  out  round-key index for AddRoundKey (0 otherwise)
//   COL_SEL    out  column index for InvMixColumns (0 otherwise)
//   DE_WE      out  one-cycle write strobe into the decrypted-message regs
//   CYCLE_CNT  out  busy cycles of the last/current run
//                   (only when AES_CTRL_CYCLE_CNT_EN is defined)
//
// Optional feature macro: AES_CTRL_CYCLE_CNT_EN
// ---------------------------------------------------------------------------
module aes_decrypt_ctrl #(
    parameter int KEYEXP_CYCLES = 10,  // legal 1..255
    parameter int CNT_W         = 16
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             AES_START,
    output logic             AES_DONE,
    output logic             BUSY,
    output logic             KEYEXP_EN,
    output logic             MSG_LD,
    output logic             STATE_LD,
    output logic [2:0]       OP_SEL,
    output logic [3:0]       ROUND_IDX,
    output logic [1:0]       COL_SEL,
`ifdef AES_CTRL_CYCLE_CNT_EN
    output logic [CNT_W-1:0] CYCLE_CNT,
`endif
    output logic             DE_WE
);

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_ARK  = 3'd1;
    localparam logic [2:0] OP_ISR  = 3'd2;
    localparam logic [2:0] OP_ISB  = 3'd3;
    localparam logic [2:0] OP_IMC  = 3'd4;

    localparam logic [7:0] KEXP_LAST   = 8'(KEYEXP_CYCLES - 1);
    localparam logic [3:0] LAST_ROUND  = 4'd10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_KEYEXP,
        S_LOAD,
        S_ARK0,
        S_ISR,
        S_ISB,
        S_ARK,
        S_IMC,
        S_DONE
    } state_t;

    state_t     state_reg;
    logic [7:0] kexp_cnt_reg;
    logic [3:0] round_reg;   // 1..9 full rounds, 10 = final round
    logic [1:0] col_reg;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg    <= S_IDLE;
            kexp_cnt_reg <= '0;
            round_reg    <= '0;
            col_reg      <= '0;
            AES_DONE     <= 1'b0;
            BUSY         <= 1'b0;
            KEYEXP_EN    <= 1'b0;
            MSG_LD       <= 1'b0;
            STATE_LD     <= 1'b0;
            DE_WE        <= 1'b0;
            OP_SEL       <= OP_NONE;
            ROUND_IDX    <= '0;
            COL_SEL      <= '0;
        end else begin
            // Every output is idle unless the state being entered says otherwise.
            AES_DONE  <= 1'b0;
            BUSY      <= 1'b0;
            KEYEXP_EN <= 1'b0;
            MSG_LD    <= 1'b0;
            STATE_LD  <= 1'b0;
            DE_WE     <= 1'b0;
            OP_SEL    <= OP_NONE;
            ROUND_IDX <= '0;
            COL_SEL   <= '0;

            case (state_reg)
                S_IDLE: begin
                    if (AES_START) begin
                        state_reg    <= S_KEYEXP;
                        kexp_cnt_reg <= '0;
                        BUSY         <= 1'b1;
                        KEYEXP_EN    <= 1'b1;
                    end
                end

                // Holding START high keeps us here. Because of this, a
                // new run needs START to go low, which passes through IDLE.
                S_DONE: begin
                    if (AES_START) AES_DONE  <= 1'b1;
                    else           state_reg <= S_IDLE;
                end

                default: begin
                    if (!AES_START) begin
                        // Abort: back to IDLE, no write strobe issued.
                        state_reg <= S_IDLE;
                    end else begin
                        BUSY <= 1'b1;
                        case (state_reg)
                            S_KEYEXP: begin
                                if (kexp_cnt_reg == KEXP_LAST) begin
                                    state_reg <= S_LOAD;
                                    MSG_LD    <= 1'b1;
                                end else begin
                                    kexp_cnt_reg <= kexp_cnt_reg + 8'd1;
                                    KEYEXP_EN    <= 1'b1;
                                end
                            end
                            S_LOAD: begin
                                state_reg <= S_ARK0;
                                STATE_LD  <= 1'b1;
                                OP_SEL    <= OP_ARK;
                                ROUND_IDX <= LAST_ROUND;
                            end
                            S_ARK0: begin
                                state_reg <= S_ISR;
                                round_reg <= 4'd1;
                                STATE_LD  <= 1'b1;
                                OP_SEL    <= OP_ISR;
                            end
                            S_ISR: begin
                                state_reg <= S_ISB;
                                STATE_LD  <= 1'b1;
                                OP_SEL    <= OP_ISB;
                            end
                            S_ISB: begin
                                state_reg <= S_ARK;
                                STATE_LD  <= 1'b1;
                                OP_SEL    <= OP_ARK;
                                ROUND_IDX <= LAST_ROUND - round_reg;
                            end
                            S_ARK: begin
                                if (round_reg == LAST_ROUND) begin
                                    // Final round skips InvMixColumns.
                                    state_reg <= S_DONE;
                                    BUSY      <= 1'b0;
                                    AES_DONE  <= 1'b1;
                                    DE_WE     <= 1'b1;
                                end else begin
                                    state_reg <= S_IMC;
                                    col_reg   <= 2'd0;
                                    STATE_LD  <= 1'b1;
                                    OP_SEL    <= OP_IMC;
                                end
                            end
                            S_IMC: begin
                                STATE_LD <= 1'b1;
                                if (col_reg == 2'd3) begin
                                    state_reg <= S_ISR;
                                    round_reg <= round_reg + 4'd1;
                                    OP_SEL    <= OP_ISR;
                                end else begin
                                    col_reg <= col_reg + 2'd1;
                                    OP_SEL  <= OP_IMC;
                                    COL_SEL <= col_reg + 2'd1;
                                end
                            end
                            default: begin
                                state_reg <= S_IDLE;
                                BUSY      <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

`ifdef AES_CTRL_CYCLE_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_reg;

    // BUSY is high during every busy cycle, so each such cycle adds one on
    // its closing edge. The count freezes once the FSM leaves the busy states.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cycle_cnt_reg <= '0;
        end else if (state_reg == S_IDLE && AES_START) begin
            cycle_cnt_reg <= '0;
        end else if (BUSY && cycle_cnt_reg != {CNT_W{1'b1}}) begin
            cycle_cnt_reg <= cycle_cnt_reg + 1'b1;
        end
    end

    assign CYCLE_CNT = cycle_cnt_reg;
`endif

endmodule

// File: tb/tb_aes_decrypt_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_decrypt_ctrl
//
// Directed testbench for aes_decrypt_ctrl. Two instances share the clock and
// reset:
//   dut_a  default KEYEXP_CYCLES = 10
//   dut_b  KEYEXP_CYCLES = 1
// Outputs are sampled 1 ns after the rising edge. Edge numbering in the
// comments: START is driven just after "edge 0", so the FSM enters KEYEXP
// at edge 1.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_aes_decrypt_ctrl;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;

    logic       done_a, busy_a, kexp_a, msg_a, st_a, dewe_a;
    logic [2:0] op_a;
    logic [3:0] idx_a;
    logic [1:0] col_a;
    logic       done_b, busy_b, kexp_b, msg_b, st_b, dewe_b;
    logic [2:0] op_b;
    logic [3:0] idx_b;
    logic [1:0] col_b;
`ifdef AES_CTRL_CYCLE_CNT_EN
    logic [15:0] cnt_a, cnt_b;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Expected per-edge output schedule: {busy,kexp,msg,st,op,idx,col,done,dewe}
    logic [14:0] sched[$];
    logic [14:0] obs_a, obs_b;
    assign obs_a = {busy_a, kexp_a, msg_a, st_a, op_a, idx_a, col_a, done_a, dewe_a};
    assign obs_b = {busy_b, kexp_b, msg_b, st_b, op_b, idx_b, col_b, done_b, dewe_b};

    always #5 CLK = ~CLK;

    aes_decrypt_ctrl #(.KEYEXP_CYCLES(10), .CNT_W(16)) dut_a (
        .CLK(CLK), .RESET_N(RESET_N), .AES_START(start_a),
        .AES_DONE(done_a), .BUSY(busy_a), .KEYEXP_EN(kexp_a),
        .MSG_LD(msg_a), .STATE_LD(st_a), .OP_SEL(op_a),
        .ROUND_IDX(idx_a), .COL_SEL(col_a),
`ifdef AES_CTRL_CYCLE_CNT_EN
        .CYCLE_CNT(cnt_a),
`endif
        .DE_WE(dewe_a)
    );

    aes_decrypt_ctrl #(.KEYEXP_CYCLES(1), .CNT_W(16)) dut_b (
        .CLK(CLK), .RESET_N(RESET_N), .AES_START(start_b),
        .AES_DONE(done_b), .BUSY(busy_b), .KEYEXP_EN(kexp_b),
        .MSG_LD(msg_b), .STATE_LD(st_b), .OP_SEL(op_b),
        .ROUND_IDX(idx_b), .COL_SEL(col_b),
`ifdef AES_CTRL_CYCLE_CNT_EN
        .CYCLE_CNT(cnt_b),
`endif
        .DE_WE(dewe_b)
    );

    function automatic logic [14:0] pk(input logic b, input logic k, input logic m,
                                       input logic s, input logic [2:0] op,
                                       input logic [3:0] idx, input logic [1:0] col,
                                       input logic d, input logic w);
        return {b, k, m, s, op, idx, col, d, w};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Hand-written schedule: KEYEXP xK, LOAD, ARK0/10, 9 rounds, final round, DONE.
    task automatic build_sched(input int k);
        sched.delete();
        for (int i = 0; i < k; i++) sched.push_back(pk(1, 1, 0, 0, 3'd0, 4'd0, 2'd0, 0, 0));
        sched.push_back(pk(1, 0, 1, 0, 3'd0, 4'd0, 2'd0, 0, 0));
        sched.push_back(pk(1, 0, 0, 1, 3'd1, 4'd10, 2'd0, 0, 0));
        for (int r = 1; r <= 9; r++) begin
            sched.push_back(pk(1, 0, 0, 1, 3'd2, 4'd0, 2'd0, 0, 0));
            sched.push_back(pk(1, 0, 0, 1, 3'd3, 4'd0, 2'd0, 0, 0));
            sched.push_back(pk(1, 0, 0, 1, 3'd1, 4'(10 - r), 2'd0, 0, 0));
            for (int c = 0; c < 4; c++)
                sched.push_back(pk(1, 0, 0, 1, 3'd4, 4'd0, 2'(c), 0, 0));
        end
        sched.push_back(pk(1, 0, 0, 1, 3'd2, 4'd0, 2'd0, 0, 0));
        sched.push_back(pk(1, 0, 0, 1, 3'd3, 4'd0, 2'd0, 0, 0));
        sched.push_back(pk(1, 0, 0, 1, 3'd1, 4'd0, 2'd0, 0, 0));
        sched.push_back(pk(0, 0, 0, 0, 3'd0, 4'd0, 2'd0, 1, 1));
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        vectors++;
        if (obs_a !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_a: got %h want 0000", obs_a);
        end
        vectors++;
        if (obs_b !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_b: got %h want 0000", obs_b);
        end
`ifdef AES_CTRL_CYCLE_CNT_EN
        vectors++;
        if (cnt_a !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_cnt: got %0d want 0", cnt_a);
        end
`endif
        @(negedge CLK);
        RESET_N = 1'b1;
        tick();
        vectors++;
        if (obs_a !== 15'd0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got %h want 0000", obs_a);
        end
    endtask

    // Full run on one instance, edge-by-edge against the schedule.
    task automatic test_trace(input bit sel_b, input int k);
        logic [14:0] o;
        build_sched(k);
        tick();                        // edge 0
        if (sel_b) start_b = 1'b1; else start_a = 1'b1;
        for (int j = 0; j < sched.size(); j++) begin
            tick();                    // edge j+1
            o = sel_b ? obs_b : obs_a;
            vectors++;
            if (o !== sched[j]) begin
                miscompares++;
                $display("FAIL trace_k%0d edge %0d: got %h want %h", k, j + 1, o, sched[j]);
            end
        end
`ifdef AES_CTRL_CYCLE_CNT_EN
        vectors++;
        if ((sel_b ? cnt_b : cnt_a) !== 16'(k + 68)) begin
            miscompares++;
            $display("FAIL cycle_cnt_k%0d: got %0d want %0d", k, sel_b ? cnt_b : cnt_a, k + 68);
        end
`endif
        tick();                        // still in DONE, strobe gone
        o = sel_b ? obs_b : obs_a;
        vectors++;
        if (o !== pk(0, 0, 0, 0, 3'd0, 4'd0, 2'd0, 1, 0)) begin
            miscompares++;
            $display("FAIL done_hold_k%0d: got %h want 0002", k, o);
        end
        if (sel_b) start_b = 1'b0; else start_a = 1'b0;
        tick();
        o = sel_b ? obs_b : obs_a;
        vectors++;
        if (o !== 15'd0) begin
            miscompares++;
            $display("FAIL done_release_k%0d: got %h want 0000", k, o);
        end
    endtask

    task automatic test_abort();
        int seen_done = 0;
        int seen_we = 0;
        tick();                        // edge 0
        start_a = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (done_a) seen_done++;
            if (dewe_a) seen_we++;
        end
        start_a = 1'b0;                // dropped after edge 40
        tick();                        // edge 41
        vectors++;
        if (obs_a !== 15'd0) begin
            miscompares++;
            $display("FAIL abort_idle: got %h want 0000", obs_a);
        end
`ifdef AES_CTRL_CYCLE_CNT_EN
        vectors++;
        if (cnt_a !== 16'd40) begin
            miscompares++;
            $display("FAIL abort_cnt: got %0d want 40", cnt_a);
        end
`endif
        for (int e = 0; e < 100; e++) begin
            tick();
            if (done_a) seen_done++;
            if (dewe_a) seen_we++;
        end
        vectors++;
        if (seen_done != 0 || seen_we != 0) begin
            miscompares++;
            $display("FAIL abort_no_done: got done=%0d we=%0d want 0/0", seen_done, seen_we);
        end
    endtask

    task automatic test_back_to_back();
        int done_edge = -1;
        int we_count = 0;
        int low_seen = 0;
        tick();                        // edge 0
        start_a = 1'b1;
        for (int e = 1; e <= 200 && done_edge < 0; e++) begin
            tick();
            if (done_a) done_edge = e;
        end
        if (dewe_a) we_count++;
        vectors++;
        if (done_edge != 79) begin
            miscompares++;
            $display("FAIL done_latency: got edge %0d want 79", done_edge);
        end
        for (int e = 0; e < 200; e++) begin
            tick();
            if (!done_a) low_seen++;
            if (dewe_a) we_count++;
        end
        vectors++;
        if (low_seen != 0 || we_count != 1) begin
            miscompares++;
            $display("FAIL hold_start: got done_low=%0d we=%0d want 0/1", low_seen, we_count);
        end
        start_a = 1'b0;
        tick();
        vectors++;
        if (done_a !== 1'b0) begin
            miscompares++;
            $display("FAIL done_drop: got %b want 0", done_a);
        end
        start_a = 1'b1;                // this edge is the new "edge 0"
        done_edge = -1;
        for (int e = 1; e <= 200 && done_edge < 0; e++) begin
            tick();
            if (done_a) done_edge = e;
        end
        vectors++;
        if (done_edge != 79) begin
            miscompares++;
            $display("FAIL rerun_latency: got edge %0d want 79", done_edge);
        end
        start_a = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        int seen_we = 0;
        tick();                        // edge 0
        start_a = 1'b1;
        repeat (17) tick();            // edge 17: round 1, IMC column 1
        vectors++;
        if (op_a !== 3'd4 || col_a !== 2'd1) begin
            miscompares++;
            $display("FAIL pre_reset_imc: got op=%0d col=%0d want 4/1", op_a, col_a);
        end
        #2;
        RESET_N = 1'b0;                // between edges
        #1;
        vectors++;
        if (obs_a !== 15'd0) begin
            miscompares++;
            $display("FAIL async_reset: got %h want 0000", obs_a);
        end
        start_a = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        for (int e = 0; e < 80; e++) begin
            tick();
            if (dewe_a || busy_a || done_a) seen_we++;
        end
        vectors++;
        if (seen_we != 0) begin
            miscompares++;
            $display("FAIL post_reset_idle: got %0d active cycles want 0", seen_we);
        end
    endtask

    initial begin
        test_reset();
        test_trace(1'b0, 10);
        test_abort();
        test_back_to_back();
        test_async_reset();
        test_trace(1'b1, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
